// File: rtl/ladowanie_wsp_pkg.sv
// Shared FIR definitions for the coefficient loader: FSM states, widths,
// default sizes and the wsp_n range check.
package ladowanie_wsp_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int MAX_WSP_DEF = 32;
  localparam int CNT_W       = 6;
  localparam int ADDR_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic n_ok(input logic [CNT_W-1:0] n, input int max_n);
    return (n != '0) && (int'(n) <= max_n);
  endfunction
endpackage

// File: rtl/ladowanie_wsp_if.sv
// Control and stream bundle of the coefficient loader. The master drives
// the requests; the slave (the loader) drives memory writes and status.
interface ladowanie_wsp_if import ladowanie_wsp_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              start;
  logic [CNT_W-1:0]  wsp_n;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              zapisz_wsp;
  logic [CNT_W-1:0]  wsp;
  logic              busy;
  logic              err;

  modport master (
    output start, wsp_n, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, zapisz_wsp, wsp, busy, err
  );
  modport slave (
    input  start, wsp_n, abort, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, zapisz_wsp, wsp, busy, err
  );
endinterface

// File: rtl/ladowanie_wsp_licznik_zapisu.sv
// Write pointer for the coefficient memory with its terminal-count flag.
// Clear has priority over increment, so the pointer never reaches count.
module licznik_zapisu #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [CNT_W-1:0]  i_count,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr  = r_ptr;
  assign o_last = (CNT_W'(r_ptr) == (i_count - CNT_W'(1)));
endmodule

// File: rtl/ladowanie_wsp.sv
// Coefficient loader: takes wsp_n words from the upstream stream, writes
// them to coefficient memory at 0..n-1, then strobes the committed count.
module ladowanie_wsp import ladowanie_wsp_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_WSP = MAX_WSP_DEF
) (
  input logic              clk,
  input logic              rst_n,
  ladowanie_wsp_if.slave   bus
);
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_wsp;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_zapisz;
  logic              r_err;

  logic              w_idle, w_load, w_n_ok, w_accept, w_reject, w_xfer, w_last, w_clr;
  logic [ADDR_W-1:0] w_ptr;

  assign w_idle   = (r_state == IDLE);
  assign w_load   = (r_state == LOAD);
  assign w_n_ok   = n_ok(bus.wsp_n, MAX_WSP);
  assign w_accept = w_idle && bus.start && w_n_ok;
  assign w_reject = w_idle && bus.start && !w_n_ok;
  // abort wins over a same-cycle word so an aborted load never writes
  assign w_xfer   = w_load && bus.in_valid && !bus.abort;
  assign w_clr    = w_accept || (w_load && bus.abort) || (w_xfer && w_last);

  licznik_zapisu #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_licznik (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_xfer),
    .i_count (r_count),
    .o_ptr   (w_ptr),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LOAD;
      LOAD:    if (bus.abort) w_state_nxt = IDLE;
               else if (w_xfer && w_last) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wsp       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_zapisz    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_xfer;
      r_zapisz <= (r_state == COMMIT);
      r_err    <= w_reject;
      if (w_accept) r_count <= bus.wsp_n;
      if (w_xfer) begin
        r_mem_addr  <= w_ptr;
        r_mem_wdata <= bus.in_data;
      end
      // the strobe lands one cycle after the final write, count alongside it
      if (r_state == COMMIT) r_wsp <= r_count;
    end
  end

  assign bus.in_ready   = w_load;
  assign bus.busy       = !w_idle;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.zapisz_wsp = r_zapisz;
  assign bus.wsp        = r_wsp;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_ladowanie_wsp.sv
// Randomized and directed bench for ladowanie_wsp against a word-count model.
module tb_ladowanie_wsp;
  localparam int DW = 16;
  localparam int MW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ladowanie_wsp_if #(.DATA_W(DW)) bus();
  ladowanie_wsp #(.DATA_W(DW), .MAX_WSP(MW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference: words still owed, one-cycle commit tail, next address
  int m_left, m_tail, m_addr, m_n;
  bit e_we, e_zap, e_err;
  int e_addr, e_wsp;
  logic [DW-1:0] e_data;
  int n_we, n_zap, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_tail = 0; m_addr = 0; m_n = 0;
    e_we = 0; e_zap = 0; e_err = 0; e_wsp = 0; e_addr = 0; e_data = '0;
  endtask

  task automatic drive(input bit s, input int n, input bit a, input bit v, input logic [DW-1:0] d);
    bus.start = s; bus.wsp_n = 6'(n); bus.abort = a; bus.in_valid = v; bus.in_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    e_we = 0; e_zap = 0; e_err = 0;
    if (m_tail > 0) begin
      m_tail = 0; e_zap = 1; e_wsp = m_n;
    end else if (m_left > 0) begin
      if (bus.abort) begin
        m_left = 0; m_addr = 0;
      end else if (bus.in_valid) begin
        e_we = 1; e_addr = m_addr; e_data = bus.in_data;
        m_addr++; m_left--;
        if (m_left == 0) begin m_tail = 1; m_addr = 0; end
      end
    end else if (bus.start) begin
      if (int'(bus.wsp_n) >= 1 && int'(bus.wsp_n) <= MW) begin
        m_left = int'(bus.wsp_n); m_n = m_left; m_addr = 0;
      end else e_err = 1;
    end
    @(negedge clk);
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("zapisz_wsp", 32'(bus.zapisz_wsp), 32'(e_zap));
    chk("err", 32'(bus.err), 32'(e_err));
    chk("busy", 32'(bus.busy), 32'(m_left > 0 || m_tail > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(m_left > 0));
    chk("wsp", 32'(bus.wsp), 32'(e_wsp));
    if (e_we) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_data));
    end
    if (bus.mem_we) n_we++;
    if (bus.zapisz_wsp) n_zap++;
    if (bus.err) n_err++;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_zap"}, 32'(bus.zapisz_wsp), 0);
    chk({tag, "_wsp"}, 32'(bus.wsp), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  // start a load, then feed randomly until the model says the block is idle
  task automatic run_load(input int n, input int vprob, input int aprob, input int sprob);
    int budget;
    drive(1, n, ($urandom % 4) == 0, 0, 16'($urandom));
    step();
    budget = 0;
    while ((m_left > 0 || m_tail > 0) && budget < 400) begin
      drive(($urandom % 100) < sprob, $urandom % 64, ($urandom % 100) < aprob,
            ($urandom % 100) < vprob, 16'($urandom));
      step();
      budget++;
    end
    if (budget >= 400) chk("load_timeout", 1, 0);
    drive(0, 0, 0, 0, '0);
    step();
  endtask

  initial begin
    int b_we, b_zap, b_err;
    model_reset();
    n_we = 0; n_zap = 0; n_err = 0;
    drive(0, 0, 0, 0, '0);
    #3 reset_chk("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // four words back to back
    b_we = n_we; b_zap = n_zap;
    drive(1, 4, 0, 0, '0); step();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 16'(16'h11 * (i + 1))); step(); end
    drive(0, 0, 0, 0, '0);
    repeat (3) step();
    chk("s4_writes", 32'(n_we - b_we), 4);
    chk("s4_commits", 32'(n_zap - b_zap), 1);

    // full depth with in_valid toggling
    b_we = n_we; b_zap = n_zap;
    drive(1, 32, 0, 0, '0); step();
    for (int i = 0; i < 200 && (m_left > 0 || m_tail > 0); i++) begin
      drive(0, 0, 0, (i % 2) == 0, 16'($urandom)); step();
    end
    drive(0, 0, 0, 0, '0);
    repeat (2) step();
    chk("s32_writes", 32'(n_we - b_we), 32);
    chk("s32_commits", 32'(n_zap - b_zap), 1);
    chk("s32_wsp", 32'(bus.wsp), 32);

    // out-of-range counts
    b_we = n_we; b_err = n_err;
    drive(1, 0, 0, 1, '0); step();
    drive(0, 0, 0, 0, '0); step();
    drive(1, 33, 0, 1, '0); step();
    drive(0, 0, 0, 0, '0); step();
    chk("bad_errs", 32'(n_err - b_err), 2);
    chk("bad_writes", 32'(n_we - b_we), 0);

    // abort on the third word, then a fresh load of 3
    b_we = n_we; b_zap = n_zap;
    drive(1, 8, 0, 0, '0); step();
    drive(0, 0, 0, 1, 16'hA0); step();
    drive(0, 0, 0, 1, 16'hA1); step();
    drive(0, 0, 1, 1, 16'hA2); step();
    drive(0, 0, 0, 0, '0); step();
    chk("abort_writes", 32'(n_we - b_we), 2);
    chk("abort_commits", 32'(n_zap - b_zap), 0);
    chk("abort_wsp", 32'(bus.wsp), 32);
    run_load(3, 100, 0, 0);

    // start during a load is ignored
    drive(1, 6, 0, 0, '0); step();
    for (int i = 0; i < 50 && (m_left > 0 || m_tail > 0); i++) begin
      drive(1, 2, 0, (i % 3) != 1, 16'($urandom)); step();
    end
    drive(0, 0, 0, 0, '0); step();
    chk("restart_wsp", 32'(bus.wsp), 6);

    // reset in the middle of a load of 5 after two writes
    b_zap = n_zap;
    drive(1, 5, 0, 0, '0); step();
    drive(0, 0, 0, 1, 16'h55); step();
    drive(0, 0, 0, 1, 16'h66); step();
    #2 rst_n = 1'b0;
    #1 reset_chk("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 16'h77);
    repeat (4) step();
    chk("rst_mid_commits", 32'(n_zap - b_zap), 0);
    drive(0, 0, 0, 0, '0); step();

    for (int it = 0; it < 30; it++)
      run_load($urandom % 40, 30 + ($urandom % 70), (($urandom % 4) == 0) ? 3 : 0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ladowanie_wsp.md
LADOWANIE_WSP -- requirements
Module: ladowanie_wsp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, coefficient word width.
REQ-002 SHALL have parameter MAX_WSP, default 32, maximum coefficient count (address space 0..31).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port wsp_n  input  6  number of coefficients to load, sampled with start.
REQ-007 SHALL have port abort  input  1  cancels an ongoing load.
REQ-008 SHALL have port in_valid  input  1  upstream coefficient valid.
REQ-009 SHALL have port in_data  input  DATA_W  upstream coefficient word.
REQ-010 SHALL have port in_ready  output  1  block accepts a coefficient this cycle.
REQ-011 SHALL have port mem_we  output  1  coefficient memory write strobe.
REQ-012 SHALL have port mem_addr  output  5  coefficient memory write address.
REQ-013 SHALL have port mem_wdata  output  DATA_W  coefficient memory write data.
REQ-014 SHALL have port zapisz_wsp  output  1  one-cycle strobe: commit coefficient count to the loop counter.
REQ-015 SHALL have port wsp  output  6  committed coefficient count, valid while zapisz_wsp high and held afterwards.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port err  output  1  one-cycle strobe: start rejected.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, COMMIT.
REQ-019 In IDLE, start with 1 <= wsp_n <= MAX_WSP SHALL latch count=wsp_n, clear write pointer to 0, and enter LOAD next cycle.
REQ-020 In IDLE, start with wsp_n == 0 or wsp_n > MAX_WSP SHALL pulse err for one cycle and remain in IDLE, with no other output change.
REQ-021 start while busy SHALL be ignored, with no err.
REQ-022 in_ready SHALL equal (state == LOAD), combinational from state only, never from in_valid.
REQ-023 A transfer SHALL occur when in_valid && in_ready && !abort.
REQ-024 Each transfer in cycle k SHALL produce mem_we=1, mem_addr=pointer, mem_wdata=in_data (registered) in cycle k+1, then increment the pointer.
REQ-025 A transfer with pointer == count-1 SHALL move the FSM to COMMIT; in_ready SHALL be 0 from cycle k+1.
REQ-026 COMMIT SHALL last exactly one cycle and return to IDLE.
REQ-027 zapisz_wsp SHALL be high for exactly one cycle, the cycle after the final mem_we, with wsp=count.
REQ-028 Gaps in in_valid SHALL stall loading indefinitely, with no timeout.
REQ-029 abort in LOAD SHALL return to IDLE next cycle, clear the pointer, discard any same-cycle transfer, and produce no zapisz_wsp; wsp SHALL keep its previous committed value.
REQ-030 abort in IDLE or COMMIT SHALL be ignored; COMMIT always completes.
REQ-031 The pointer SHALL never exceed MAX_WSP-1; wrap-around is impossible by construction.
REQ-032 mem_we, zapisz_wsp and err SHALL be 0 in every cycle not specified above.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, pointer=0, count=0, wsp=0, mem_we=0, mem_addr=0, mem_wdata=0, zapisz_wsp=0, err=0, in_ready=0, busy=0.
REQ-034 Reset mid-LOAD SHALL abandon the load without a commit strobe; deassertion SHALL be followed by IDLE.

Structure
REQ-035 The state enum, MAX_WSP and DATA_W defaults SHALL live in the shared FIR package.
REQ-036 The write pointer with its terminal-count compare SHALL be one sub-module, licznik_zapisu; everything else SHALL be flat.

Verification
REQ-037 start, wsp_n=4, in_valid held high, data 0x0011..0x0044 -> mem_we on 4 consecutive cycles at addr 0..3; zapisz_wsp one cycle later with wsp=4; busy low next cycle.
REQ-038 wsp_n=32, in_valid toggling 1/0 -> 32 writes at addr 0..31 in order; zapisz_wsp once with wsp=32.
REQ-039 start with wsp_n=0, then with wsp_n=33 -> err pulses once each; busy stays 0; no mem_we.
REQ-040 wsp_n=8, abort coincident with the 3rd transfer -> exactly 2 writes (addr 0,1); no zapisz_wsp; wsp unchanged; a following load of 3 writes from addr 0.
REQ-041 rst_n asserted mid-clock during a load of 5 after 2 writes -> all outputs 0 immediately, before the next edge; no zapisz_wsp after release.
REQ-042 start pulsed during LOAD with wsp_n=2 -> ignored; the original count of 6 completes with wsp=6.
